// File: rtl/exu_div_pkg.sv
// Shared definitions for the RV32M iterative divider.
//   - op codes for DIV / DIVU / REM / REMU
//   - FSM state encoding
//   - step counter width
//   - helper to take the magnitude of a possibly-signed operand
package exu_div_pkg;

    localparam int unsigned DIV_CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'b00,
        DIV_STATE_CALC = 2'b01,
        DIV_STATE_DONE = 2'b10
    } div_state_e;

    // Two's-complement magnitude when the value is treated as signed and negative.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] div_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exu_div.sv
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         pipeline flush, aborts any operation (priority over start_i)
//   start_i         request an operation, sampled only in IDLE
//   op_i            DIV_OP_* code
//   dividend_i      rs1 data
//   divisor_i       rs2 data
//   rd_waddr_i      destination register
//   busy_o          stall request (combinational)
//   ready_o         one-cycle result-valid pulse
//   result_o        quotient or remainder, held until the next completion
//   rd_waddr_o      destination register captured at start
//   rd_we_o         equals ready_o
module exu_div
    import exu_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_waddr_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_waddr_o,
    output logic            rd_we_o
);

    div_state_e               state_q;
    logic [DIV_CNT_WIDTH-1:0] cnt_q;
    logic [XLEN-1:0]          rem_q;
    logic [XLEN-1:0]          quot_q;
    logic [XLEN-1:0]          dvs_q;
    logic                     is_rem_q;
    logic                     neg_quot_q;
    logic                     neg_rem_q;

    logic                     start_ok;
    logic                     op_signed;
    logic                     op_is_rem;
    logic [XLEN:0]            rem_shift;
    logic [XLEN:0]            rem_diff;
    logic                     step_ge;
    logic [XLEN-1:0]          rem_nxt;
    logic [XLEN-1:0]          quot_nxt;
    logic [XLEN-1:0]          final_res;

    assign start_ok  = (state_q == DIV_STATE_IDLE) && start_i && !flush_i;
    assign op_signed = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    assign op_is_rem = (op_i == DIV_OP_REM) || (op_i == DIV_OP_REMU);

    // One restoring step. The remainder is always below the divisor, so after the
    // shift it is below 2*divisor and the 33-bit difference's MSB is a clean borrow.
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        step_ge   = ~rem_diff[XLEN];
        rem_nxt   = step_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_nxt  = {quot_q[XLEN-2:0], step_ge};
        if (is_rem_q) begin
            final_res = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
        end else begin
            final_res = neg_quot_q ? (~quot_nxt + 1'b1) : quot_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_STATE_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= '0;
            rd_waddr_o <= '0;
        end else if (flush_i) begin
            state_q <= DIV_STATE_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                DIV_STATE_IDLE: begin
                    if (start_i) begin
                        is_rem_q   <= op_is_rem;
                        rd_waddr_o <= rd_waddr_i;
                        neg_quot_q <= op_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_rem_q  <= op_signed && dividend_i[XLEN-1];
                        rem_q      <= '0;
                        quot_q     <= div_mag(dividend_i, op_signed);
                        dvs_q      <= div_mag(divisor_i, op_signed);
                        cnt_q      <= '0;
                        if (divisor_i == '0) begin
                            // RISC-V divide-by-zero results, no iteration needed
                            result_o <= op_is_rem ? dividend_i : '1;
                            state_q  <= DIV_STATE_DONE;
                        end else begin
                            state_q <= DIV_STATE_CALC;
                        end
                    end
                end
                DIV_STATE_CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        result_o <= final_res;
                        state_q  <= DIV_STATE_DONE;
                    end
                end
                DIV_STATE_DONE: begin
                    state_q <= DIV_STATE_IDLE;
                end
                default: begin
                    state_q <= DIV_STATE_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state_q == DIV_STATE_CALC) || start_ok;
    assign ready_o = (state_q == DIV_STATE_DONE) && !flush_i;
    assign rd_we_o = ready_o;

endmodule

// File: tb/tb_exu_div.sv
module tb_exu_div;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_in;
    logic        busy;
    logic        ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        rd_we;

    int n_cmp = 0;
    int n_err = 0;

    exu_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .rd_waddr_i (rd_in),
        .busy_o     (busy),
        .ready_o    (ready),
        .result_o   (result),
        .rd_waddr_o (rd_out),
        .rd_we_o    (rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V semantics via 64-bit arithmetic (C-style truncating / and %).
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return 32'(ua / ub);
            2'b10:   return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    // Issue one op and check timing, busy profile, result and the one-cycle pulse.
    // poke > 0 pulses a bogus start_i at that cycle offset during CALC.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int poke);
        int lat;
        int busy_cnt;
        int exp_lat;
        @(posedge clk); #1;
        start = 1'b1; op = o; dividend = a; divisor = b; rd_in = rd;
        #1 chk("busy_start", {31'd0, busy}, 32'd1);
        exp_lat  = (b == 32'd0) ? 1 : 33;
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == poke) begin
                start = 1'b1; op = ~o; dividend = $urandom; divisor = $urandom | 32'd1;
                rd_in = ~rd;
            end
            #1;
            if (busy) busy_cnt++;
        end while (!ready && lat < 100);
        start = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        chk("result", result, exp);
        chk("rd_waddr", {27'd0, rd_out}, {27'd0, rd});
        chk("rd_we", {31'd0, rd_we}, 32'd1);
        @(posedge clk); #1;
        chk("ready_pulse", {31'd0, ready}, 32'd0);
        chk("result_hold", result, exp);
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ready) n++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int          nr;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{2'b00, 32'd100,        32'd7,          5'd3,  32'd14};
        vecs[1] = '{2'b10, 32'd100,        32'd7,          5'd4,  32'd2};
        vecs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'h7FFF_FFFC};
        vecs[5] = '{2'b11, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'd1};
        vecs[6] = '{2'b01, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF};
        vecs[7] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          5'd10, 32'hFFFF_FFF9};
        vecs[8] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000};
        vecs[9] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0};

        rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 2'b00;
        dividend = '0; divisor = '0; rd_in = '0;
        #12;
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 0);

        // Flush at N+10, restart at N+12 with 9/3, result at N+45.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; dividend = 32'd100; divisor = 32'd7; rd_in = 5'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1 chk("flush_ready", {31'd0, ready}, 32'd0);
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        do_op(2'b00, 32'd9, 32'd3, 5'd14, 32'd3, 0);

        // Flush coinciding with DONE suppresses the pulse.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd15;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && !ready; i++) begin
            @(posedge clk); #1;
        end
        chk("done_reached", {31'd0, ready}, 32'd1);
        flush = 1'b1;
        #1 chk("flush_done_ready", {31'd0, ready}, 32'd0);
        chk("flush_done_we", {31'd0, rd_we}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        count_ready(3, nr);
        chk("flush_done_no_pulse", 32'(nr), 32'd0);

        // Flush has priority over start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b00; dividend = 32'd8; divisor = 32'd2;
        #1 chk("flush_prio_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_prio_idle", {31'd0, busy}, 32'd0);
        count_ready(40, nr);
        chk("flush_prio_no_ready", 32'(nr), 32'd0);

        // Second start during CALC is ignored.
        do_op(2'b00, 32'd1000, 32'd9, 5'd16, 32'd111, 5);

        // Reset at N+5.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; dividend = 32'd77; divisor = 32'd5; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd", {27'd0, rd_out}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_ready(40, nr);
        chk("midrst_no_ready", 32'(nr), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd1;
                3:       rb = 32'($urandom_range(1, 15));
                4:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 5'($urandom_range(0, 31)), model(ro, ra, rb), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_div.md
Name: exu_div

Overview:
- Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Lives inside the execute stage and consumes operands straight from the ID/EX pipeline register outputs: rs1/rs2 data, rd address, and decoded op.
- While an operation is in flight it raises a busy request, which the EXU turns into an EX-stage stall.
- It returns the result with a one-cycle ready pulse; a pipeline flush aborts it.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush; aborts any operation
- start_i  in  1  request an operation; sampled only in IDLE
- op_i  in  2  DIV_OP_DIV / DIV_OP_DIVU / DIV_OP_REM / DIV_OP_REMU
- dividend_i  in  32  rs1 data
- divisor_i  in  32  rs2 data
- rd_waddr_i  in  5  destination register
- busy_o  out  1  stall request (combinational)
- ready_o  out  1  result valid; one-cycle pulse
- result_o  out  32  quotient or remainder
- rd_waddr_o  out  5  destination register captured at start
- rd_we_o  out  1  equals ready_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; result_o, rd_waddr_o, ready_o, rd_we_o and all internal registers 0. busy_o is 0 while start_i is 0.
- States:
  - IDLE, CALC, DONE. Encoding is 2 bits, taken from the shared package.
- Start:
  - In IDLE with start_i=1 and flush_i=0, capture op, rd_waddr, operand magnitudes and result-sign flags.
  - Signed ops: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Unsigned ops: operands used raw, both sign flags 0.
  - start_i outside IDLE is ignored.
- Divisor zero (checked at start):
  - Go straight to DONE.
  - DIV/DIVU: result = 0xFFFFFFFF.
  - REM/REMU: result = dividend_i, unmodified.
  - ready_o is high in cycle N+1, where N is the start cycle.
- Normal path:
  - Transition to CALC with a 5-bit counter = 0.
  - Each CALC cycle performs one restoring-division step: shift the {rem, quot} pair left 1; compare rem with the divisor magnitude; subtract and set quot[0] on success.
  - Counter wraps 31->0; on the 32nd step go to DONE.
  - On the DONE entry edge, apply sign correction by 2's-complement negate and load result_o.
  - ready_o is high in cycle N+33.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF falls out naturally as q=0x80000000, r=0. No special path is needed; the bench checks it.
- DONE: ready_o=1 and rd_we_o=1 for exactly one cycle, then IDLE. result_o and rd_waddr_o hold until the next completion.
- busy_o:
  - busy_o = (state==CALC) | (state==IDLE & start_i & ~flush_i).
  - busy_o is 0 in DONE, so the pipeline advances in the ready cycle.
  - A new start_i is accepted in the first IDLE cycle after DONE.
- flush_i:
  - From any state, next state is IDLE and the counter is cleared.
  - ready_o stays 0 in the next cycle; if flush_i coincides with DONE, ready_o is forced to 0 that cycle.
  - flush_i has priority over start_i in the same cycle.
- Reset mid-operation: asynchronous return to the reset values; no ready pulse.
- Width rules:
  - Remainder datapath is 33 bits, to hold the compare/subtract.
  - Magnitude of 0x80000000 is the unsigned value 0x80000000.

Decomposition:
- Shared definitions in defines.sv:
  - DIV_OP_* codes: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
  - DIV_STATE_* encodings.
  - DIV_CNT_WIDTH=5.
- No sub-module; the datapath registers may use gen_en_dff.

Test Plan:
- DIV 100 / 7, start at cycle N -> busy_o high for cycles N..N+32; ready_o=1 only at N+33; result 14, rd_waddr_o echoed; REM of the same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU of the same operands -> 0x7FFFFFFC.
- DIVU 5/0 -> 0xFFFFFFFF at N+1; REM 0xFFFFFFF9/0 -> 0xFFFFFFF9 at N+1; no CALC cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush_i at N+10 -> IDLE at N+11 with no ready pulse; start at N+12 with 9/3 -> result 3 at N+45.
- Second start_i pulsed during CALC is ignored (result matches the first op). rst_n low at N+5 -> all outputs 0 immediately, no ready pulse.
